alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one 32-bit ALU datapath (the gate-level mux/and/or result selection) between N requesters.
//  Round-robin grant, one operation in flight at a time. Drives the ALU operand and op lines and
//  holds them stable for a fixed ALU_LAT cycles. Returns each result on a tagged response channel.
// PARAMETERS
//  N        4   number of requesters (2..8)
//  W        32  operand/result width
//  OPW      3   ALU opcode width
//  ALU_LAT  1   cycles operands are held before alu_res is sampled (>=1)
// PORTS
//  clk        in   1        rising-edge clock
//  reset_n    in   1        synchronous active-low reset
//  req_valid  in   N        per-requester request valid
//  req_a      in   N*W      operand A; requester i at [i*W +: W]
//  req_b      in   N*W      operand B; same packing as req_a
//  req_op     in   N*OPW    opcode; requester i at [i*OPW +: OPW]
//  req_ready  out  N        one-hot accept strobe
//  alu_a      out  W        registered operand A to the shared ALU
//  alu_b      out  W        registered operand B to the shared ALU
//  alu_op     out  OPW      registered opcode to the shared ALU
//  alu_res    in   W        ALU result, valid ALU_LAT cycles after operands change
//  rsp_valid  out  1        response valid
//  rsp_ready  in   1        response consumer ready
//  rsp_id     out  clog2(N) index of the requester that owns rsp_data
//  rsp_data   out  W        captured ALU result
//  busy       out  1        state != IDLE
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): state=IDLE, rr_ptr=0, cnt=0. alu_a/alu_b/alu_op/rsp_data/rsp_id=0.
//    rsp_valid=0, req_ready=0. Reset wins over every other event, including mid-WAIT/RESP.
//    An in-flight op is dropped with no response.
//  FSM states: IDLE, WAIT, RESP.
//  IDLE: grant g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod N.
//    req_ready is combinational, req_ready[g]=1 only in IDLE. Handshake = req_valid[g] & req_ready[g].
//    On handshake: alu_a/b/op <= req_*[g], rsp_id <= g, rr_ptr <= (g+1) mod N,
//    cnt <= ALU_LAT-1, -> WAIT. No valid request: stay in IDLE, outputs hold.
//  WAIT: alu_* held stable. cnt!=0: cnt--. cnt==0: rsp_data <= alu_res, rsp_valid <= 1, -> RESP.
//  RESP: rsp_valid, rsp_id and rsp_data held stable until rsp_ready=1. On that edge rsp_valid <= 0, -> IDLE.
//    req_ready=0 throughout WAIT and RESP.
//  Timing: accept edge T; rsp_valid high from T+ALU_LAT+1.
//    Minimum issue period ALU_LAT+2 cycles (rsp_ready tied 1).
//  Requesters hold req_valid/req_* until accepted. Dropping valid before grant is legal, and that requester is skipped.
//  alu_* keep the last operation's values in IDLE. No combinational path from alu_res to any output.
//  Opcode is opaque: passed through unmodified, no decoding.
//  rr_ptr advances only on a grant. After reset, requester 0 has highest priority.
// TESTING
//  1 reset_n=0 for 2 cycles with req_valid=4'hF -> req_ready=0, rsp_valid=0, alu_*=0, busy=0.
//    After release, first grant is req_ready=4'b0001.
//  2 ALU_LAT=1, only req 2: a=5, b=3, op=3'b010, ALU model adds -> req_ready=4'b0100 for 1 cycle.
//    2 cycles later: rsp_valid=1, rsp_id=2, rsp_data=8.
//  3 req_valid=4'hF held, rsp_ready=1 -> grants in order 0,1,2,3,0, one every 3 cycles.
//    Each rsp_id matches its grant.
//  4 rsp_ready=0 for 5 cycles during RESP -> rsp_valid, rsp_id, rsp_data stable; req_ready=0.
//    Grant resumes the cycle after rsp_ready=1.
//  5 reset_n=0 for one cycle during WAIT after granting req 1 -> IDLE next cycle, no rsp_valid.
//    Next grant goes to req 0 if valid.
//  6 ALU_LAT=3, a=32'hFFFF_FFFF, b=32'h0000_FFFF, op=AND -> alu_* stable 3 cycles.
//    rsp_valid at accept+4, rsp_data=32'h0000_FFFF.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU datapath among N tagged requesters
module alu_share_arbiter #(
  parameter int N       = 4,
  parameter int W       = 32,
  parameter int OPW     = 3,
  parameter int ALU_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N-1:0]          req_valid,
  input  logic [N*W-1:0]        req_a,
  input  logic [N*W-1:0]        req_b,
  input  logic [N*OPW-1:0]      req_op,
  output logic [N-1:0]          req_ready,
  output logic [W-1:0]          alu_a,
  output logic [W-1:0]          alu_b,
  output logic [OPW-1:0]        alu_op,
  input  logic [W-1:0]          alu_res,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [$clog2(N)-1:0]  rsp_id,
  output logic [W-1:0]          rsp_data,
  output logic                  busy
);

  localparam int IDW = $clog2(N);
  // cnt must be at least one bit wide even when ALU_LAT=1 (it then only ever holds 0)
  localparam int CW  = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   cand;
  logic             grant_found;
  logic             accept;
  logic [CW-1:0]    cnt;

  logic [W-1:0]     a_arr  [N];
  logic [W-1:0]     b_arr  [N];
  logic [OPW-1:0]   op_arr [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign a_arr[i]  = req_a[i*W +: W];
    assign b_arr[i]  = req_b[i*W +: W];
    assign op_arr[i] = req_op[i*OPW +: OPW];
  end

  // Round-robin search: walk backwards so the candidate closest to rr_ptr is the last one kept
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IDW'((int'(rr_ptr) + k) % N);
      if (req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Next-state logic and the one-hot accept strobe (only offered in IDLE, never while reset is low)
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (reset_n && grant_found) begin
          accept               = 1'b1;
          req_ready[grant_idx] = 1'b1;
          state_nxt            = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == '0) state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Operand launch, latency countdown, result capture and response handshake
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr    <= '0;
      cnt       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
    end else begin
      if (accept) begin
        alu_a  <= a_arr[grant_idx];
        alu_b  <= b_arr[grant_idx];
        alu_op <= op_arr[grant_idx];
        rsp_id <= grant_idx;
        rr_ptr <= IDW'((int'(grant_idx) + 1) % N);
        cnt    <= CW'(ALU_LAT - 1);
      end else if (state == S_WAIT && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (state == S_WAIT && cnt == '0) begin
        rsp_data  <= alu_res;
        rsp_valid <= 1'b1;
      end
      if (state == S_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter (ALU_LAT=1 and ALU_LAT=3 instances)
module tb_alu_share_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int OPW = 3;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU_LAT=1 instance
  logic [N-1:0]     req_valid, req_ready;
  logic [N*W-1:0]   req_a, req_b;
  logic [N*OPW-1:0] req_op;
  logic [W-1:0]     alu_a, alu_b, alu_res, rsp_data;
  logic [OPW-1:0]   alu_op;
  logic             rsp_valid, rsp_ready, busy;
  logic [1:0]       rsp_id;

  // ALU_LAT=3 instance
  logic [N-1:0]     l3_req_valid, l3_req_ready;
  logic [N*W-1:0]   l3_req_a, l3_req_b;
  logic [N*OPW-1:0] l3_req_op;
  logic [W-1:0]     l3_alu_a, l3_alu_b, l3_alu_res, l3_rsp_data;
  logic [OPW-1:0]   l3_alu_op;
  logic             l3_rsp_valid, l3_rsp_ready, l3_busy;
  logic [1:0]       l3_rsp_id;

  // Shared ALU behaviour seen by both instances
  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [OPW-1:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b011:  return a - b;
      3'b100:  return a ^ b;
      3'b101:  return a << b[4:0];
      3'b110:  return ~a;
      default: return b;
    endcase
  endfunction

  assign alu_res    = alu_fn(alu_a, alu_b, alu_op);
  assign l3_alu_res = alu_fn(l3_alu_a, l3_alu_b, l3_alu_op);

  alu_share_arbiter #(.N(N), .W(W), .OPW(OPW), .ALU_LAT(1)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_ready(req_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  alu_share_arbiter #(.N(N), .W(W), .OPW(OPW), .ALU_LAT(3)) u_dut_lat3 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(l3_req_valid), .req_a(l3_req_a), .req_b(l3_req_b), .req_op(l3_req_op),
    .req_ready(l3_req_ready),
    .alu_a(l3_alu_a), .alu_b(l3_alu_b), .alu_op(l3_alu_op), .alu_res(l3_alu_res),
    .rsp_valid(l3_rsp_valid), .rsp_ready(l3_rsp_ready), .rsp_id(l3_rsp_id),
    .rsp_data(l3_rsp_data), .busy(l3_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
  endtask

  typedef struct {
    int             id;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [OPW-1:0] op;
    logic [W-1:0]   res;
    int             due;
  } exp_t;

  exp_t sb_q[$];
  int   model_rr = 0;
  bit   rsp_seen = 0;
  int   grant_ids[$];
  int   grant_cyc[$];
  bit   rand_en  = 0;

  // Monitor / scoreboard for the ALU_LAT=1 instance: reference round-robin, expected results, timing
  always @(negedge clk) begin
    int           g;
    logic [N-1:0] exp_rdy;
    exp_t         e;
    if (!reset_n) begin
      sb_q.delete();
      model_rr = 0;
      rsp_seen = 0;
    end else begin
      if (!busy)
        check((req_valid != 0) == (req_ready != 0), "grant_present", req_ready, req_valid);
      if (req_ready != 0) begin
        g = -1;
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(model_rr + k) % N]) g = (model_rr + k) % N;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check(req_ready == exp_rdy, "grant_rr", req_ready, exp_rdy);
        if (g >= 0) begin
          e.id  = g;
          e.a   = req_a[g*W +: W];
          e.b   = req_b[g*W +: W];
          e.op  = req_op[g*OPW +: OPW];
          e.res = alu_fn(e.a, e.b, e.op);
          e.due = cyc + 2;
          sb_q.push_back(e);
          model_rr = (g + 1) % N;
          grant_ids.push_back(g);
          grant_cyc.push_back(cyc);
        end
      end
      if (busy) begin
        check(req_ready == 0, "ready_while_busy", req_ready, 0);
        if (sb_q.size() > 0)
          check(alu_a == sb_q[0].a && alu_b == sb_q[0].b && alu_op == sb_q[0].op, "alu_operands",
                {alu_op, alu_a}, {sb_q[0].op, sb_q[0].a});
      end
      if (rsp_valid) begin
        check(sb_q.size() > 0, "rsp_expected", rsp_id, 0);
        if (sb_q.size() > 0) begin
          if (!rsp_seen) begin
            check(cyc == sb_q[0].due, "rsp_latency", cyc, sb_q[0].due);
            rsp_seen = 1;
          end
          check(rsp_id == 2'(sb_q[0].id) && rsp_data == sb_q[0].res, "rsp_payload",
                {rsp_id, rsp_data}, {2'(sb_q[0].id), sb_q[0].res});
          if (rsp_ready) begin
            void'(sb_q.pop_front());
            rsp_seen = 0;
          end
        end
      end
    end
  end

  // Random requester/consumer driver: holds requests until accepted, sometimes withdraws them
  always begin
    logic [N-1:0] hs;
    @(negedge clk);
    hs = req_ready & req_valid;
    @(posedge clk);
    #1;
    if (rand_en) begin
      for (int i = 0; i < N; i++) begin
        if (hs[i] || !req_valid[i]) begin
          req_valid[i] = hs[i] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
          req_a[i*W +: W]       = $urandom;
          req_b[i*W +: W]       = $urandom;
          req_op[i*OPW +: OPW]  = OPW'($urandom_range(0, 7));
        end else if ($urandom_range(0, 19) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
    end
  end

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      done = !busy && !rsp_valid && sb_q.size() == 0;
    end
    check(done, name, busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks so far %0d", n_checks);
    $fatal(1);
  end

  initial begin
    int           exp_ids[5];
    logic [1:0]   id0;
    logic [W-1:0] d0;
    bit           seen;
    exp_ids = '{0, 1, 2, 3, 0};

    // reset with every request asserted
    reset_n      = 1'b0;
    req_valid    = '1;
    req_a        = {$urandom, $urandom, $urandom, $urandom};
    req_b        = {$urandom, $urandom, $urandom, $urandom};
    req_op       = 12'($urandom);
    rsp_ready    = 1'b1;
    l3_req_valid = '0;
    l3_req_a     = '0;
    l3_req_b     = '0;
    l3_req_op    = '0;
    l3_rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check(req_ready == 0, "rst_req_ready", req_ready, 0);
    check(rsp_valid == 0, "rst_rsp_valid", rsp_valid, 0);
    check(alu_a == 0 && alu_b == 0 && alu_op == 0, "rst_alu", {alu_op, alu_a, alu_b}, 0);
    check(busy == 0 && rsp_id == 0 && rsp_data == 0, "rst_rsp", {busy, rsp_id, rsp_data}, 0);
    check(l3_req_ready == 0 && l3_busy == 0 && l3_rsp_valid == 0, "rst_lat3",
          {l3_req_ready, l3_busy, l3_rsp_valid}, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    grant_ids.delete();
    grant_cyc.delete();
    @(negedge clk);
    check(req_ready == 4'b0001, "first_grant", req_ready, 4'b0001);

    // continuous traffic: grants 0,1,2,3,0 three cycles apart
    for (int k = 0; k < 40 && grant_ids.size() < 5; k++) @(negedge clk);
    check(grant_ids.size() >= 5, "rr_grant_count", grant_ids.size(), 5);
    for (int k = 0; k < 5 && k < grant_ids.size(); k++) begin
      check(grant_ids[k] == exp_ids[k], "rr_order", grant_ids[k], exp_ids[k]);
      if (k > 0) check(grant_cyc[k] - grant_cyc[k-1] == 3, "rr_period", grant_cyc[k] - grant_cyc[k-1], 3);
    end
    @(posedge clk);
    #1 req_valid = '0;
    wait_idle("idle_after_rr");

    // single request from requester 2: 5 + 3
    @(posedge clk);
    #1;
    req_a[2*W +: W]      = 32'd5;
    req_b[2*W +: W]      = 32'd3;
    req_op[2*OPW +: OPW] = 3'b010;
    req_valid            = 4'b0100;
    @(negedge clk);
    check(req_ready == 4'b0100, "t2_grant", req_ready, 4'b0100);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check(req_ready == 0 && rsp_valid == 0, "t2_wait", {req_ready, rsp_valid}, 0);
    @(negedge clk);
    check(rsp_valid == 1 && rsp_id == 2 && rsp_data == 32'd8, "t2_rsp",
          {rsp_valid, rsp_id, rsp_data}, {1'b1, 2'd2, 32'd8});
    wait_idle("idle_after_t2");

    // response back-pressure while other requests wait
    @(posedge clk);
    #1;
    rsp_ready       = 1'b0;
    req_a[1*W +: W] = $urandom;
    req_valid       = 4'b0010;
    @(negedge clk);
    check(req_ready == 4'b0010, "t4_grant", req_ready, 4'b0010);
    @(posedge clk);
    #1 req_valid = 4'b1111;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    check(seen, "t4_rsp_arrives", seen, 1);
    id0 = rsp_id;
    d0  = rsp_data;
    check(id0 == 2'd1, "t4_rsp_id", id0, 1);
    repeat (5) begin
      @(negedge clk);
      check(rsp_valid && rsp_id == id0 && rsp_data == d0, "t4_hold",
            {rsp_valid, rsp_id, rsp_data}, {1'b1, id0, d0});
      check(req_ready == 0, "t4_ready_low", req_ready, 0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check(req_ready == 4'b0100, "t4_resume", req_ready, 4'b0100);
    @(posedge clk);
    #1 req_valid = '0;
    wait_idle("idle_after_t4");

    // reset during WAIT drops the operation and restarts priority at requester 0
    @(posedge clk);
    #1 req_valid = 4'b0010;
    @(negedge clk);
    check(req_ready == 4'b0010, "t5_grant", req_ready, 4'b0010);
    @(posedge clk);
    #1;
    reset_n   = 1'b0;
    req_valid = 4'b1111;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check(!busy && !rsp_valid, "t5_idle", {busy, rsp_valid}, 0);
    check(req_ready == 4'b0001, "t5_regrant", req_ready, 4'b0001);
    @(posedge clk);
    #1 req_valid = '0;
    wait_idle("idle_after_t5");

    // ALU_LAT=3 instance: operands held three cycles, response at accept+4
    @(posedge clk);
    #1;
    l3_req_a[0 +: W]   = 32'hFFFF_FFFF;
    l3_req_b[0 +: W]   = 32'h0000_FFFF;
    l3_req_op[0 +: OPW] = 3'b000;
    l3_req_valid       = 4'b0001;
    @(negedge clk);
    check(l3_req_ready == 4'b0001, "t6_grant", l3_req_ready, 4'b0001);
    @(posedge clk);
    #1 l3_req_valid = '0;
    repeat (3) begin
      @(negedge clk);
      check(l3_alu_a == 32'hFFFF_FFFF && l3_alu_b == 32'h0000_FFFF && l3_alu_op == 3'b000,
            "t6_alu_hold", {l3_alu_op, l3_alu_a, l3_alu_b}, {3'b000, 32'hFFFF_FFFF, 32'h0000_FFFF});
      check(!l3_rsp_valid && l3_busy && l3_req_ready == 0, "t6_wait",
            {l3_rsp_valid, l3_busy, l3_req_ready}, {1'b0, 1'b1, 4'b0});
    end
    @(negedge clk);
    check(l3_rsp_valid && l3_rsp_id == 0 && l3_rsp_data == 32'h0000_FFFF, "t6_rsp",
          {l3_rsp_valid, l3_rsp_id, l3_rsp_data}, {1'b1, 2'd0, 32'h0000_FFFF});

    // randomized traffic against the scoreboard
    grant_ids.delete();
    grant_cyc.delete();
    @(posedge clk);
    #1 rand_en = 1'b1;
    repeat (3000) @(posedge clk);
    #1;
    rand_en   = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle("idle_after_random");
    check(grant_ids.size() > 200, "random_activity", grant_ids.size(), 200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
